// File: rtl/ddr_sdram_ex_pkg.sv
// Shared types and constants for the DDR SDRAM example driver read-data checker.
package ddr_sdram_ex_pkg;

    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned LFSR_W    = 8;
    // Galois feedback for x^8+x^4+x^3+x^2+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr8_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], 1'b0} ^ (q[LFSR_W-1] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/ddr_sdram_ex_lfsr8.sv
// 8-bit pattern LFSR: reloads its seed when disabled or loaded, holds while paused.
module ddr_sdram_ex_lfsr8
    import ddr_sdram_ex_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load,
    input  logic              pause,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else if (!enable || load) begin
            q <= SEED;
        end else if (!pause) begin
            q <= lfsr8_step(q);
        end
    end

endmodule

// File: rtl/ddr_sdram_ex_rdata_checker.sv
// Read-data checker: regenerates the per-lane write pattern and scores SDRAM read beats.
module ddr_sdram_ex_rdata_checker
    import ddr_sdram_ex_pkg::*;
#(
    parameter int unsigned DQ_BYTES  = 2,
    parameter int unsigned SEED      = 32,
    parameter int unsigned NUM_BEATS = 64,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rdata_valid,
    input  logic [8*DQ_BYTES-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DQ_BYTES-1:0]   lane_err,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ERR_CNT_W-1:0]  first_err_beat
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    chk_state_e           state, state_d;
    logic [LFSR_W-1:0]    lfsr_q [DQ_BYTES];
    logic [DQ_BYTES-1:0]  mism_c;
    logic                 lfsr_en, lfsr_pause;
    logic                 chk_beat, last_beat, tmr_expire, any_mism, pass_c;
    logic [ERR_CNT_W-1:0] beat_cnt;
    logic [TMR_W-1:0]     tmr;

    // One pattern generator per byte lane, each on its own seed
    for (genvar k = 0; k < DQ_BYTES; k++) begin : g_lane
        ddr_sdram_ex_lfsr8 #(
            .SEED (LFSR_W'((SEED + k) % 256))
        ) u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (lfsr_en),
            .load    (1'b0),
            .pause   (lfsr_pause),
            .q       (lfsr_q[k])
        );
        assign mism_c[k] = (rdata[8*k +: 8] != lfsr_q[k]);
    end

    assign lfsr_en    = (state == ST_CHECK);
    assign lfsr_pause = !rdata_valid;
    assign chk_beat   = (state == ST_CHECK) && rdata_valid;
    assign any_mism   = chk_beat && (|mism_c);
    assign last_beat  = chk_beat && (beat_cnt == ERR_CNT_W'(NUM_BEATS - 1));
    // A valid beat on the expiry cycle wins over the timeout
    assign tmr_expire = (state == ST_CHECK) && !rdata_valid && (tmr == TMR_W'(TIMEOUT - 1));
    assign pass_c     = (err_count == '0) && !timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (start) state_d = ST_ARM;
            ST_ARM:    state_d = ST_CHECK;
            ST_CHECK:  if (last_beat || tmr_expire) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            lane_err       <= '0;
            err_count      <= '0;
            first_err_beat <= '0;
            beat_cnt       <= '0;
            tmr            <= '0;
        end else begin
            busy <= (state_d == ST_ARM) || (state_d == ST_CHECK);
            done <= (state == ST_FINISH);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        timeout        <= 1'b0;
                        lane_err       <= '0;
                        err_count      <= '0;
                        first_err_beat <= '0;
                    end
                end
                ST_ARM: begin
                    beat_cnt <= '0;
                    tmr      <= '0;
                end
                ST_CHECK: begin
                    if (rdata_valid) begin
                        beat_cnt <= beat_cnt + ERR_CNT_W'(1);
                        tmr      <= '0;
                        if (any_mism) begin
                            lane_err <= lane_err | mism_c;
                            fail     <= 1'b1;
                            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                            if (err_count == '0) first_err_beat <= beat_cnt;
                        end
                    end else if (tmr_expire) begin
                        timeout <= 1'b1;
                        fail    <= 1'b1;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_FINISH: begin
                    pass <= pass_c;
                    fail <= !pass_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_sdram_ex_rdata_checker.sv
// Randomized scoreboard bench for the read-data checker, with a saturation run on a second instance.
module tb_ddr_sdram_ex_rdata_checker;

    localparam int unsigned NB = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned SAT_NB = 65535;

    typedef struct {
        logic [1:0]  lane_err;
        logic [15:0] err_count;
        logic [15:0] first_err_beat;
        logic        pass;
        logic        fail;
        logic        timeout;
        int          latency;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, rdata_valid = 1'b0;
    logic [15:0] rdata = '0;
    logic        busy, done, pass, fail, timeout;
    logic [1:0]  lane_err;
    logic [15:0] err_count, first_err_beat;

    logic        s_start = 1'b0, s_valid = 1'b0;
    logic [7:0]  s_rdata = '0;
    logic        s_busy, s_done, s_pass, s_fail, s_timeout;
    logic [0:0]  s_lane_err;
    logic [15:0] s_err_count, s_first_err_beat;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, last_edge = 0;
    exp_t exp_q[$];
    exp_t sat_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr_sdram_ex_rdata_checker #(.DQ_BYTES(2), .SEED(32), .NUM_BEATS(NB), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rdata_valid(rdata_valid), .rdata(rdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .lane_err(lane_err), .err_count(err_count), .first_err_beat(first_err_beat));

    ddr_sdram_ex_rdata_checker #(.DQ_BYTES(1), .SEED(200), .NUM_BEATS(SAT_NB), .TIMEOUT(TO)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(s_start), .rdata_valid(s_valid), .rdata(s_rdata),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
        .lane_err(s_lane_err), .err_count(s_err_count), .first_err_beat(s_first_err_beat));

    // Pattern as polynomial arithmetic: multiply by x modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] ref_next(input logic [7:0] v);
        logic [8:0] w;
        w = {v, 1'b0};
        if (w[8]) w = w ^ 9'h11D;
        return w[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: score each done pulse against the oldest expected result
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pass", 32'(pass), 32'(e.pass));
                chk("fail", 32'(fail), 32'(e.fail));
                chk("timeout", 32'(timeout), 32'(e.timeout));
                chk("lane_err", 32'(lane_err), 32'(e.lane_err));
                chk("err_count", 32'(err_count), 32'(e.err_count));
                chk("first_err_beat", 32'(first_err_beat), 32'(e.first_err_beat));
                chk("done_latency", 32'(cyc - last_edge), 32'(e.latency));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && s_done) begin
            if (sat_q.size() == 0) begin
                chk("sat_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sat_q.pop_front();
                chk("sat_err_count", 32'(s_err_count), 32'(e.err_count));
                chk("sat_first_err_beat", 32'(s_first_err_beat), 32'(e.first_err_beat));
                chk("sat_lane_err", 32'(s_lane_err), 32'(e.lane_err));
                chk("sat_pass_fail", 32'({s_pass, s_fail, s_timeout}), 32'({e.pass, e.fail, e.timeout}));
            end
        end
    end

    task automatic pulse_start(input bit garbage);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Beat presented during ARM must be ignored
        rdata_valid = garbage;
        rdata = 16'($urandom);
        @(posedge clk); #1;
        rdata_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            chk(name, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Send n_sent beats; fewer than NB ends in timeout. fix_beat/fix_xor plant a directed corruption.
    task automatic drive_pass(input int n_sent, input int gap_lo, input int gap_hi,
                              input int corrupt_pct, input int fix_beat, input logic [15:0] fix_xor,
                              input bit push);
        logic [7:0]  m0, m1;
        logic [15:0] err;
        exp_t        e;
        m0 = 8'd32;
        m1 = 8'd33;
        e.lane_err = '0; e.err_count = '0; e.first_err_beat = '0;
        pulse_start($urandom_range(0, 1) == 1);
        for (int b = 0; b < n_sent; b++) begin
            repeat ($urandom_range(gap_lo, gap_hi)) @(posedge clk);
            #1;
            if (b == fix_beat) err = fix_xor;
            else if (int'($urandom_range(0, 99)) < corrupt_pct) err = 16'($urandom);
            else err = '0;
            rdata_valid = 1'b1;
            rdata = {m1, m0} ^ err;
            start = ($urandom_range(0, 3) == 0);
            if (err != 0) begin
                if (e.err_count == 0) e.first_err_beat = 16'(b);
                e.err_count++;
                e.lane_err |= {err[15:8] != 0, err[7:0] != 0};
            end
            m0 = ref_next(m0);
            m1 = ref_next(m1);
            @(posedge clk); #1;
            last_edge = cyc;
            rdata_valid = 1'b0;
            start = 1'b0;
        end
        e.timeout = (n_sent < int'(NB));
        e.pass    = (e.err_count == 0) && !e.timeout;
        e.fail    = !e.pass;
        e.latency = e.timeout ? int'(TO) + 1 : 1;
        if (push) begin
            exp_q.push_back(e);
            wait_drained("done_missing");
        end
    endtask

    initial begin
        logic [7:0] sm;
        exp_t       se;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, done, pass, fail, timeout, lane_err, err_count, first_err_beat}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({busy, done, pass, fail}), 32'd0);

        drive_pass(NB, 0, 0, 0, -1, 16'h0000, 1'b1);   // clean back-to-back
        drive_pass(NB, 0, 0, 0, 2, 16'h0001, 1'b1);    // 0x80 -> 0x81 on beat 2, lane 0
        drive_pass(NB, 5, 5, 0, -1, 16'h0000, 1'b1);   // 5-cycle gaps
        drive_pass(2, 0, 0, 0, -1, 16'h0000, 1'b1);    // timeout after 2 beats
        drive_pass(NB, 0, 0, 0, 0, 16'h0100, 1'b1);    // lane 1 only on beat 0
        drive_pass(NB, TO - 1, TO - 1, 0, -1, 16'h0000, 1'b1); // beat lands on the expiry cycle

        // Asynchronous reset mid-pass clears everything at once
        drive_pass(2, 0, 1, 0, -1, 16'h0000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_pass", 32'({busy, done, pass, fail, timeout, lane_err, err_count, first_err_beat}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (TO + 4) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(exp_q.size()), 32'd0);
        drive_pass(NB, 0, 2, 0, -1, 16'h0000, 1'b1);

        for (int i = 0; i < 16; i++) begin
            drive_pass(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NB - 1)) : int'(NB),
                       0, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 1)) * 40,
                       -1, 16'h0000, 1'b1);
        end

        // Saturation: every beat of a 65535-beat pass corrupt
        sm = 8'd200;
        se.lane_err = 2'b01; se.err_count = 16'hFFFF; se.first_err_beat = '0;
        se.pass = 1'b0; se.fail = 1'b1; se.timeout = 1'b0; se.latency = 1;
        sat_q.push_back(se);
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < int'(SAT_NB); b++) begin
            s_valid = 1'b1;
            s_rdata = sm ^ 8'($urandom_range(1, 255));
            sm = ref_next(sm);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sat_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("sat_done_seen", 32'(sat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
